// File: rtl/matmult_seq.sv
// Sequential N x N signed matrix multiplier: C = A*B or C = C + A*B using one MAC per cycle.
// Optional macro MATMULT_SAT_EN: saturating C writes plus a sat_flag output.
module matmult_seq #(
  parameter int N  = 5,
  parameter int DW = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              acc_mode,
  input  logic [N*N*DW-1:0] a_in,
  input  logic [N*N*DW-1:0] b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef MATMULT_SAT_EN
  output logic              sat_flag,
`endif
  output logic [N*N*DW-1:0] c_out
);

  localparam int NE   = N * N;
  localparam int IW   = $clog2(N);
  localparam int EW   = $clog2(NE);
  localparam int PW   = 2 * DW;
  localparam int ACCW = 2 * DW + $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_reg, state_next;

  logic signed [DW-1:0]   a_mem [NE];
  logic signed [DW-1:0]   b_mem [NE];
  logic signed [DW-1:0]   c_mem [NE];
  logic [IW-1:0]          i_reg, j_reg, k_reg;
  logic signed [ACCW-1:0] acc_reg;
  logic                   mode_reg;
  logic                   out_valid_reg, out_valid_next;

  logic [EW-1:0]          a_idx, b_idx, c_idx, c_next_idx;
  logic                   k_last, j_last, last_elem;
  logic signed [PW-1:0]   a_ext, b_ext, prod;
  logic signed [ACCW-1:0] sum, c_first_ext, c_next_ext;
  logic [DW-1:0]          wr_val;
`ifdef MATMULT_SAT_EN
  logic                   ovf;
  logic                   sat_reg;
  logic [ACCW-DW:0]       sum_upper;
`endif

  // Operand addressing and the single MAC
  always_comb begin
    a_idx       = EW'(i_reg) * EW'(N) + EW'(k_reg);
    b_idx       = EW'(k_reg) * EW'(N) + EW'(j_reg);
    c_idx       = EW'(i_reg) * EW'(N) + EW'(j_reg);
    k_last      = (k_reg == IW'(N - 1));
    j_last      = (j_reg == IW'(N - 1));
    last_elem   = (i_reg == IW'(N - 1)) && j_last;
    c_next_idx  = last_elem ? '0 : c_idx + EW'(1);
    a_ext       = PW'(a_mem[a_idx]);
    b_ext       = PW'(b_mem[b_idx]);
    prod        = a_ext * b_ext;
    sum         = acc_reg + ACCW'(prod);
    c_first_ext = ACCW'(c_mem[0]);
    c_next_ext  = ACCW'(c_mem[c_next_idx]);
`ifdef MATMULT_SAT_EN
    // In range only when every bit from the DW sign bit upward agrees
    sum_upper = sum[ACCW-1:DW-1];
    ovf       = !(&sum_upper) && (|sum_upper);
    if (ovf)
      wr_val = sum[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      wr_val = sum[DW-1:0];
`else
    wr_val = sum[DW-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // out_valid is registered, so it rises one cycle after DONE is entered
  always_comb begin
    state_next     = state_reg;
    in_ready       = 1'b0;
    busy           = 1'b0;
    out_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (k_last && last_elem) state_next = DONE;
      end
      DONE: begin
        out_valid_next = 1'b1;
        if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < NE; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
        c_mem[e] <= '0;
      end
      i_reg         <= '0;
      j_reg         <= '0;
      k_reg         <= '0;
      acc_reg       <= '0;
      mode_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
`ifdef MATMULT_SAT_EN
      sat_reg       <= 1'b0;
`endif
    end else begin
      out_valid_reg <= out_valid_next;
      case (state_reg)
        IDLE: if (in_valid) begin
          for (int e = 0; e < NE; e++) begin
            a_mem[e] <= a_in[e*DW +: DW];
            b_mem[e] <= b_in[e*DW +: DW];
          end
          mode_reg <= acc_mode;
          i_reg    <= '0;
          j_reg    <= '0;
          k_reg    <= '0;
          acc_reg  <= acc_mode ? c_first_ext : '0;
`ifdef MATMULT_SAT_EN
          sat_reg  <= 1'b0;
`endif
        end
        CALC: if (k_last) begin
          c_mem[c_idx] <= wr_val;
          // Seed the next element's sum with its old value when accumulating
          acc_reg <= (mode_reg && !last_elem) ? c_next_ext : '0;
          k_reg   <= '0;
`ifdef MATMULT_SAT_EN
          sat_reg <= sat_reg | ovf;
`endif
          if (j_last) begin
            j_reg <= '0;
            i_reg <= last_elem ? '0 : i_reg + IW'(1);
          end else begin
            j_reg <= j_reg + IW'(1);
          end
        end else begin
          acc_reg <= sum;
          k_reg   <= k_reg + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
`ifdef MATMULT_SAT_EN
  assign sat_flag = sat_reg;
`endif

  for (genvar gi = 0; gi < NE; gi++) begin : g_c_out
    assign c_out[gi*DW +: DW] = c_mem[gi];
  end

endmodule

// File: tb/tb_matmult_seq.sv
// Directed bench for matmult_seq: a 2x2/8-bit instance from a vector table and a 5x5/64-bit instance
// checked against a modulo-2^64 model.
module tb_matmult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        v2, r2, m2, ov2, ordy2, busy2;
  logic [31:0] a2, b2, c2;
  logic          v5, r5, m5, ov5, ordy5, busy5;
  logic [1599:0] a5, b5, c5;
`ifdef MATMULT_SAT_EN
  logic sat2, sat5;
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  matmult_seq #(.N(2), .DW(8)) d2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .acc_mode(m2),
    .a_in(a2), .b_in(b2), .out_valid(ov2), .out_ready(ordy2), .busy(busy2),
`ifdef MATMULT_SAT_EN
    .sat_flag(sat2),
`endif
    .c_out(c2));

  matmult_seq #(.N(5), .DW(64)) d5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(r5), .acc_mode(m5),
    .a_in(a5), .b_in(b5), .out_valid(ov5), .out_ready(ordy5), .busy(busy5),
`ifdef MATMULT_SAT_EN
    .sat_flag(sat5),
`endif
    .c_out(c5));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m2x2(input int e00, input int e01, input int e10, input int e11);
    return {8'(e11), 8'(e10), 8'(e01), 8'(e00)};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
    logic [31:0] exp_wrap;
    logic [31:0] exp_sat;
    logic        flag;
  } vec_t;
  vec_t vt[6];

  // Accept one job on the small instance, then count cycles to out_valid and busy cycles
  task automatic run2(input logic [31:0] a, input logic [31:0] b, input logic mode,
                      output int lat, output int busy_cnt);
    int t;
    t = 0;
    while (!r2 && t < 50) begin @(posedge clk); #1; t++; end
    a2 = a; b2 = b; m2 = mode; v2 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0; a2 = $urandom; b2 = $urandom; m2 = ~mode;
    lat = 0; busy_cnt = 0;
    while (!ov2 && lat < 200) begin
      if (busy2) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic rel2(input string name);
    ordy2 = 1'b1;
    @(posedge clk); #1;
    ordy2 = 1'b0;
    check({name, " out_valid drop"}, 1600'(ov2), 1600'(0));
    check({name, " in_ready back"}, 1600'(r2), 1600'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bc, t;
    logic [31:0] exp2;
    longint ae[25], be[25], ev[25], pv[25];
    longint s;
    logic [63:0] x;
    logic [1599:0] exp5;

    vt[0] = '{m2x2(1,2,3,4), m2x2(5,6,7,8), 1'b0, m2x2(19,22,43,50), m2x2(19,22,43,50), 1'b0};
    vt[1] = '{m2x2(1,2,3,4), m2x2(5,6,7,8), 1'b1, m2x2(38,44,86,100), m2x2(38,44,86,100), 1'b0};
    vt[2] = '{m2x2(127,127,127,127), m2x2(127,127,127,127), 1'b0, m2x2(2,2,2,2), m2x2(127,127,127,127), 1'b1};
    vt[3] = '{m2x2(-128,-128,-128,-128), m2x2(127,127,127,127), 1'b0, m2x2(0,0,0,0), m2x2(-128,-128,-128,-128), 1'b1};
    vt[4] = '{m2x2(-1,2,3,-4), m2x2(5,-6,7,8), 1'b0, m2x2(9,22,-13,-50), m2x2(9,22,-13,-50), 1'b0};
    vt[5] = '{m2x2(1,0,0,1), m2x2(1,1,1,1), 1'b1, m2x2(10,23,-12,-49), m2x2(10,23,-12,-49), 1'b0};

    rst = 1'b1;
    v2 = 0; m2 = 0; a2 = '0; b2 = '0; ordy2 = 0;
    v5 = 0; m5 = 0; a5 = '0; b5 = '0; ordy5 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 1600'({r2, r5}), 1600'(2'b11));
    check("reset out_valid", 1600'({ov2, ov5}), 1600'(0));
    check("reset busy", 1600'({busy2, busy5}), 1600'(0));
    check("reset c_out", c5 | 1600'(c2), 1600'(0));
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run2(vt[v].a, vt[v].b, vt[v].mode, lat, bc);
      exp2 = SAT ? vt[v].exp_sat : vt[v].exp_wrap;
      $display("vec %0d: a=%h b=%h mode=%0d c=%h exp=%h lat=%0d busy=%0d", v, vt[v].a, vt[v].b, vt[v].mode, c2, exp2, lat, bc);
      check($sformatf("vec%0d latency", v), 1600'(lat), 1600'(9));
      check($sformatf("vec%0d busy cycles", v), 1600'(bc), 1600'(8));
      check($sformatf("vec%0d c_out", v), 1600'(c2), 1600'(exp2));
`ifdef MATMULT_SAT_EN
      check($sformatf("vec%0d sat_flag", v), 1600'(sat2), 1600'(vt[v].flag));
`endif
      rel2($sformatf("vec%0d", v));
    end

    // Backpressure: result held, new operands ignored
    run2(vt[4].a, vt[4].b, 1'b0, lat, bc);
    exp2 = vt[4].exp_wrap;
    for (int cyc = 0; cyc < 20; cyc++) begin
      v2 = cyc[0]; a2 = $urandom; b2 = $urandom;
      @(posedge clk); #1;
      check("hold out_valid", 1600'(ov2), 1600'(1));
      check("hold in_ready", 1600'(r2), 1600'(0));
      check("hold c_out", 1600'(c2), 1600'(exp2));
    end
    v2 = 1'b0;
    $display("backpressure: c=%h exp=%h", c2, exp2);
    rel2("backpressure");

    // Reset in the middle of CALC discards the partial result
    a2 = vt[0].a; b2 = vt[0].b; m2 = 1'b0; v2 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("mid-calc reset: c=%h in_ready=%0d out_valid=%0d busy=%0d", c2, r2, ov2, busy2);
    check("midrst in_ready", 1600'(r2), 1600'(1));
    check("midrst out_valid", 1600'(ov2), 1600'(0));
    check("midrst busy", 1600'(busy2), 1600'(0));
    check("midrst c_out", 1600'(c2), 1600'(0));
    run2(vt[0].a, vt[0].b, 1'b1, lat, bc);
    $display("acc after reset: c=%h lat=%0d", c2, lat);
    check("post-reset acc c_out", 1600'(c2), 1600'(vt[0].exp_wrap));
    check("post-reset latency", 1600'(lat), 1600'(9));
    rel2("post-reset");

    // 5x5 / 64-bit jobs against a modulo-2^64 model
    for (int e = 0; e < 25; e++) pv[e] = 0;
    for (int job = 0; job < 100; job++) begin
      m5 = (job % 4 == 3);
      for (int e = 0; e < 25; e++) begin
        x = {$urandom, $urandom};
        ae[e] = SAT ? longint'($signed(x[19:0])) : longint'(x);
        x = {$urandom, $urandom};
        be[e] = SAT ? longint'($signed(x[19:0])) : longint'(x);
        a5[e*64 +: 64] = ae[e];
        b5[e*64 +: 64] = be[e];
      end
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) begin
          s = m5 ? pv[i*5+j] : 0;
          for (int k = 0; k < 5; k++) s += ae[i*5+k] * be[k*5+j];
          ev[i*5+j] = s;
          exp5[(i*5+j)*64 +: 64] = s;
        end
      t = 0;
      while (!r5 && t < 50) begin @(posedge clk); #1; t++; end
      v5 = 1'b1;
      @(posedge clk); #1;
      v5 = 1'b0; a5 = '0; b5 = '1;
      lat = 0;
      while (!ov5 && lat < 400) begin @(posedge clk); #1; lat++; end
      $display("job %0d: mode=%0d lat=%0d c00=%h exp00=%h", job, m5, lat, c5[63:0], exp5[63:0]);
      check($sformatf("job%0d latency", job), 1600'(lat), 1600'(126));
      check($sformatf("job%0d c_out", job), c5, exp5);
`ifdef MATMULT_SAT_EN
      check($sformatf("job%0d sat_flag", job), 1600'(sat5), 1600'(0));
`endif
      for (int e = 0; e < 25; e++) pv[e] = ev[e];
      ordy5 = 1'b1;
      @(posedge clk); #1;
      ordy5 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
